// File: rtl/data_ram_responder.sv
// Data-side memory for the MEM stage: one-entry posted write buffer, one-cycle reads
// with full byte-lane forwarding, plus a side-effect-free debug read port.
module data_ram_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_addr_err,
    input  logic [31:0] test_addr,
    output logic [31:0] test_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    logic                  wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0] wb_idx_q, wb_idx_d;
    logic [3:0]            wb_be_q, wb_be_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           tdata_q, tdata_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] idx, tidx;
    logic                  in_range, t_in_range;
    logic [31:0]           mem_rd, mem_td;
    logic                  unused_ok;

    assign idx        = dm_addr[ADDR_WIDTH+1:2];
    assign tidx       = test_addr[ADDR_WIDTH+1:2];
    assign in_range   = (dm_addr[31:ADDR_WIDTH+2] == '0);
    assign t_in_range = (test_addr[31:ADDR_WIDTH+2] == '0);
    assign mem_rd     = mem[idx];
    assign mem_td     = mem[tidx];
    assign unused_ok  = ^{dm_addr[1:0], test_addr[1:0]};

    // Buffer holds a write for exactly one cycle; out-of-range writes never enter it.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_idx_d   = wb_idx_q;
        wb_be_d    = wb_be_q;
        wb_data_d  = wb_data_q;
        if (dm_wen != 4'b0000 && in_range) begin
            wb_valid_d = 1'b1;
            wb_idx_d   = idx;
            wb_be_d    = dm_wen;
            wb_data_d  = dm_wdata;
        end
    end

    // Per-lane priority: current write, then buffered write, then array.
    always_comb begin
        rdata_d = '0;
        tdata_d = '0;
        err_d   = !in_range;
        for (int i = 0; i < 4; i++) begin
            if (in_range) begin
                if (dm_wen[i])
                    rdata_d[8*i +: 8] = dm_wdata[8*i +: 8];
                else if (wb_valid_q && wb_idx_q == idx && wb_be_q[i])
                    rdata_d[8*i +: 8] = wb_data_q[8*i +: 8];
                else
                    rdata_d[8*i +: 8] = mem_rd[8*i +: 8];
            end
            if (t_in_range) begin
                if (wb_valid_q && wb_idx_q == tidx && wb_be_q[i])
                    tdata_d[8*i +: 8] = wb_data_q[8*i +: 8];
                else
                    tdata_d[8*i +: 8] = mem_td[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_be_q    <= '0;
            wb_data_q  <= '0;
            rdata_q    <= '0;
            tdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_idx_q   <= wb_idx_d;
            wb_be_q    <= wb_be_d;
            wb_data_q  <= wb_data_d;
            rdata_q    <= rdata_d;
            tdata_q    <= tdata_d;
            err_q      <= err_d;
        end
    end

    // Array is not reset; a reset clears wb_valid_q so a pending write is discarded.
    always_ff @(posedge clk) begin
        if (wb_valid_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_be_q[i]) mem[wb_idx_q][8*i +: 8] <= wb_data_q[8*i +: 8];
            end
        end
    end

    assign dm_rdata    = rdata_q;
    assign test_data   = tdata_q;
    assign dm_addr_err = err_q;
endmodule

// File: tb/tb_data_ram_responder.sv
// Table-driven bench for data_ram_responder: hand-derived load data per row, debug
// port checked against an architectural memory model through a scoreboard queue.
module tb_data_ram_responder;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] dm_addr, dm_wdata, test_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_rdata, test_data;
    logic        dm_addr_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] taddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] tdata;
        logic        tvalid;
        int          row;
    } exp_t;

    vec_t        vecs[27];
    exp_t        sb[$];
    logic [31:0] model[int];

    data_ram_responder #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .resetn(resetn),
        .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_addr_err(dm_addr_err),
        .test_addr(test_addr), .test_data(test_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit oor(input logic [31:0] a);
        return a[31:12] != 20'h0;
    endfunction

    // Drive one row; the model memory is updated instantly, so the debug port (which
    // never sees the current write) expects the pre-write contents.
    task automatic step(input int row, input vec_t v);
        exp_t e, got;
        int   k;
        @(negedge clk);
        dm_addr = v.addr; dm_wen = v.wen; dm_wdata = v.wdata; test_addr = v.taddr;
        e.row = row; e.rdata = v.exp_rdata; e.err = v.exp_err;
        k = int'(v.taddr[31:2]);
        if (oor(v.taddr)) begin
            e.tdata = 32'h0; e.tvalid = 1'b1;
        end else if (model.exists(k)) begin
            e.tdata = model[k]; e.tvalid = 1'b1;
        end else begin
            e.tdata = 32'h0; e.tvalid = 1'b0;
        end
        k = int'(v.addr[31:2]);
        if (!oor(v.addr) && v.wen != 4'b0) begin
            logic [31:0] w;
            w = model.exists(k) ? model[k] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (v.wen[i]) w[8*i +: 8] = v.wdata[8*i +: 8];
            model[k] = w;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("row%0d dm_rdata", got.row), dm_rdata, got.rdata);
        chk($sformatf("row%0d dm_addr_err", got.row), {31'h0, dm_addr_err}, {31'h0, got.err});
        if (got.tvalid)
            chk($sformatf("row%0d test_data", got.row), test_data, got.tdata);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{32'h0000_0000, 4'hF, 32'h0101_0101, 32'h0000_0000, 32'h0101_0101, 1'b0};
        vecs[1]  = '{32'h0000_0010, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[2]  = '{32'h0000_0040, 4'hF, 32'h0000_0000, 32'h0000_0010, 32'h0000_0000, 1'b0};
        vecs[3]  = '{32'h0000_0080, 4'hF, 32'h5555_5555, 32'h0000_0040, 32'h5555_5555, 1'b0};
        vecs[4]  = '{32'h0000_0010, 4'h0, 32'h0000_0000, 32'h0000_0010, 32'hCAFE_F00D, 1'b0};
        vecs[5]  = '{32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{32'h0000_0020, 4'h0, 32'h0000_0000, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{32'h0000_0020, 4'h0, 32'h0000_0000, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{32'h0000_0040, 4'h1, 32'h0000_00AA, 32'h0000_0040, 32'h0000_00AA, 1'b0};
        vecs[9]  = '{32'h0000_0040, 4'h4, 32'h00BB_0000, 32'h0000_0040, 32'h00BB_00AA, 1'b0};
        vecs[10] = '{32'h0000_0040, 4'h0, 32'h0000_0000, 32'h0000_0040, 32'h00BB_00AA, 1'b0};
        vecs[11] = '{32'h0000_0040, 4'hF, 32'h1234_5678, 32'h0000_0040, 32'h1234_5678, 1'b0};
        vecs[12] = '{32'h0000_0040, 4'h3, 32'h0000_ABCD, 32'h0000_0040, 32'h1234_ABCD, 1'b0};
        vecs[13] = '{32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0040, 32'h0101_0101, 1'b0};
        vecs[14] = '{32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0040, 32'h0101_0101, 1'b0};
        vecs[15] = '{32'h0000_0040, 4'h0, 32'h0000_0000, 32'h0000_0040, 32'h1234_ABCD, 1'b0};
        vecs[16] = '{32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[17] = '{32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_1000, 32'h0101_0101, 1'b0};
        vecs[18] = '{32'hFFFF_FFFC, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[19] = '{32'h0000_0080, 4'hF, 32'h9ABC_DEF0, 32'h0000_0080, 32'h9ABC_DEF0, 1'b0};
        vecs[20] = '{32'h0000_0080, 4'h0, 32'h0000_0000, 32'h0000_0080, 32'h9ABC_DEF0, 1'b0};
        vecs[21] = '{32'h0000_0080, 4'h0, 32'h0000_0000, 32'h0000_0080, 32'h9ABC_DEF0, 1'b0};
        vecs[22] = '{32'h0000_0080, 4'h0, 32'h0000_0000, 32'h0000_0080, 32'h9ABC_DEF0, 1'b0};
        vecs[23] = '{32'h0000_0080, 4'h0, 32'h0000_0000, 32'h0000_0080, 32'h9ABC_DEF0, 1'b0};
        vecs[24] = '{32'h0000_0080, 4'h8, 32'h1100_0000, 32'h0000_0080, 32'h11BC_DEF0, 1'b0};
        vecs[25] = '{32'h0000_0080, 4'h0, 32'h0000_0000, 32'h0000_0080, 32'h11BC_DEF0, 1'b0};
        vecs[26] = '{32'h0000_0000, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0101_0101, 1'b0};

        resetn = 1'b0; dm_addr = '0; dm_wen = '0; dm_wdata = '0; test_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset dm_rdata", dm_rdata, 32'h0);
        chk("reset test_data", test_data, 32'h0);
        chk("reset dm_addr_err", {31'h0, dm_addr_err}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int r = 0; r < 4; r++) step(r, vecs[r]);

        // Write pending in the buffer when reset hits mid-cycle must be lost.
        v = '{32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0000_0010, 32'h1122_3344, 1'b0};
        step(100, v);
        #2;
        resetn = 1'b0;
        dm_wen = 4'h0;
        #1;
        chk("async reset dm_rdata", dm_rdata, 32'h0);
        chk("async reset test_data", test_data, 32'h0);
        chk("async reset dm_addr_err", {31'h0, dm_addr_err}, 32'h0);
        model[32'h10 >> 2] = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int r = 4; r < 27; r++) step(r, vecs[r]);

        chk("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
Data-side memory responder for the five-stage CPU. It sits on the MEM-stage data port (dm_addr/dm_wen/dm_wdata in, dm_rdata out) and serves it.
- Byte-lane writes go through a one-entry posted write buffer.
- Reads are synchronous with one-cycle latency and forward any pending buffered bytes.
- A second read-only debug port shows memory contents to the display/test logic.

Parameters:
ADDR_WIDTH, 10, word-address bits; the array is 2^ADDR_WIDTH x 32-bit words (4 KB default).

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
dm_addr  input  32  byte address from MEM stage; bits [1:0] ignored
dm_wen  input  4  byte-lane write enables, bit i = byte lane [8i+7:8i]
dm_wdata  input  32  write data, already lane-aligned by MEM stage
dm_rdata  output  32  registered read data for the address presented last cycle
dm_addr_err  output  1  registered flag: last-cycle access was out of range
test_addr  input  32  debug byte address; bits [1:0] ignored
test_data  output  32  registered debug read data

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (resetn).
- Reset values:
  - dm_rdata = 0, test_data = 0, dm_addr_err = 0.
  - Write buffer invalid (wb_valid = 0).
  - Array contents are not reset.
  - A buffered write pending when resetn falls is discarded.
- Address decode:
  - idx = dm_addr[ADDR_WIDTH+1:2].
  - in_range = (dm_addr[31:ADDR_WIDTH+2] == 0).
  - The debug port decodes test_addr the same way.
- Write buffer state: wb_valid, wb_idx, wb_be[3:0], wb_data[31:0].
- Each rising edge, in this order of effect:
  1. If wb_valid: array[wb_idx] lanes with wb_be=1 take wb_data lanes (commit).
  2. If dm_wen != 0 and in_range: the buffer loads {idx, dm_wen, dm_wdata} and wb_valid <= 1.
  3. Otherwise wb_valid <= 0.
- The buffer therefore holds one write for exactly one cycle. Back-to-back writes stream with no stall. Program order is preserved, including back-to-back writes to the same word: the older write commits and the newer one is buffered.
- Read path (no request signal; every cycle is treated as a read of dm_addr). Next dm_rdata is built per lane, with priority from highest to lowest:
  - current dm_wen lane (if in_range), using dm_wdata;
  - else buffered lane (wb_valid and wb_idx==idx and wb_be lane), using wb_data;
  - else array[idx].
- This gives write-first semantics and full read-after-write forwarding with zero bubbles. The MEM stage sees load data exactly one edge after presenting the address.
- Out-of-range access:
  - The write is dropped and not buffered.
  - Next dm_rdata = 0.
  - dm_addr_err = 1 for that one cycle (registered; it follows dm_addr one cycle later).
  - The array and any pending buffer commit are unaffected.
- dm_wen == 0 performs a pure read. dm_wdata is ignored.
- A held address (MEM stall) yields the same dm_rdata each cycle, updated if a buffered commit changes that word.
- Debug port:
  - next test_data uses the same forwarding from buffer and array, but not from the current dm_wen.
  - It returns 0 if test_addr is out of range.
  - It has no side effects. There is no contention with the main port: the array has one write port and two read ports.
- Alignment and lane placement are the MEM stage's responsibility; this block never shifts data.

Test Plan:
- Reset then read: resetn=0 asynchronously mid-cycle -> dm_rdata=0, test_data=0, dm_addr_err=0 immediately. With a pending write 0x11223344 at addr 0x10 during reset, a later read of 0x10 returns the pre-reset array value.
- Word write then read: cycle0 addr 0x20, wen 1111, wdata 0xDEADBEEF; cycle1 wen 0, addr 0x20 -> dm_rdata 0xDEADBEEF after the cycle0 edge (write-first) and again after the cycle1 edge (buffer forward). Cycle3 test_addr 0x20 -> test_data 0xDEADBEEF.
- Byte merge back-to-back: preload 0x00000000 at 0x40; write wen 0001/0xAA, then wen 0100/0x00BB0000, then read 0x40 -> 0x00BB00AA with no idle cycles.
- Same-word overwrite ordering: write 0x40 wen 1111 0x12345678, next cycle wen 0011 0x0000ABCD, then read after two idle cycles -> 0x1234ABCD.
- Out of range (ADDR_WIDTH=10): addr 0x00001000, wen 1111, wdata 0xFFFFFFFF -> dm_rdata 0, dm_addr_err=1 for one cycle only; a read of 0x0 is unchanged (aliasing write dropped).
- Stall hold: addr 0x80 held 4 cycles with wen 0 while a prior write to 0x80 commits -> dm_rdata shows the written value on every cycle and no glitch to the old value.
